// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x3 telephone keypad scanner.
// Codes: digits as BCD, star and hash as 4'b1010 / 4'b1011.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] k;
    k = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    k = KEY_STAR;
        2'd1:    k = 4'h0;
        default: k = KEY_HASH;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row-scanning keypad front end with 2-FF column synchronizer,
// press/release debounce and a registered code/valid/pulse output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [3:0]          code,
  output logic                valid,
  output logic                key_pulse
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);
  localparam logic [1:0] ROW_LAST = 2'(NUM_ROWS - 1);

  logic [NUM_COLS-1:0] r_col_m;
  logic [NUM_COLS-1:0] r_col_s;
  state_t              r_state;
  state_t              w_state;
  logic [1:0]          r_row;
  logic [1:0]          w_row;
  logic [1:0]          w_row_inc;
  logic [DW-1:0]       r_dwell;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt;
  logic [1:0]          r_cand_row;
  logic [1:0]          w_cand_row;
  logic [1:0]          r_cand_col;
  logic [1:0]          w_cand_col;
  logic [3:0]          r_code;
  logic [3:0]          w_code;
  logic                r_valid;
  logic                w_valid;
  logic                r_pulse;
  logic                w_pulse;
  logic [NUM_ROWS-1:0] r_row_out;
  logic [NUM_ROWS-1:0] w_row_out;
  logic                w_tick;
  logic                w_single;
  logic [1:0]          w_col;
  logic                w_match;

  // Columns are active low; leftmost column sits on the MSB.
  always_comb begin
    w_single = 1'b1;
    w_col    = 2'd0;
    unique case (r_col_s)
      3'b011:  w_col = 2'd0;
      3'b101:  w_col = 2'd1;
      3'b110:  w_col = 2'd2;
      default: w_single = 1'b0;
    endcase
  end

  assign w_tick    = (r_dwell == DWELL_LAST);
  assign w_match   = w_single && (w_col == r_cand_col);
  assign w_row_inc = (r_row == ROW_LAST) ? 2'd0 : r_row + 2'd1;
  assign w_row_out = ~(ROW_ONE << w_row);

  always_comb begin
    w_state    = r_state;
    w_row      = r_row;
    w_cnt      = r_cnt;
    w_cand_row = r_cand_row;
    w_cand_col = r_cand_col;
    w_code     = r_code;
    w_valid    = r_valid;
    w_pulse    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_single) begin
            w_cand_row = r_row;
            w_cand_col = w_col;
            w_cnt      = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              w_state = PRESSED;
              w_code  = key_code(r_row, w_col);
              w_valid = 1'b1;
              w_pulse = 1'b1;
            end else begin
              w_state = DEBOUNCE;
            end
          end else begin
            w_row = w_row_inc;
          end
        end
        DEBOUNCE: begin
          if (w_match) begin
            if (r_cnt == CNT_LAST) begin
              w_state = PRESSED;
              w_code  = key_code(r_cand_row, r_cand_col);
              w_valid = 1'b1;
              w_pulse = 1'b1;
            end else begin
              w_cnt = r_cnt + 1'b1;
            end
          end else begin
            w_state = SCAN;
            w_row   = w_row_inc;
          end
        end
        PRESSED: begin
          if (!w_match) begin
            w_cnt = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              w_state = SCAN;
              w_valid = 1'b0;
              w_row   = w_row_inc;
            end else begin
              w_state = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (w_match) begin
            w_state = PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            w_state = SCAN;
            w_valid = 1'b0;
            w_row   = w_row_inc;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_m    <= '1;
      r_col_s    <= '1;
      r_state    <= SCAN;
      r_row      <= 2'd0;
      r_dwell    <= '0;
      r_cnt      <= '0;
      r_cand_row <= 2'd0;
      r_cand_col <= 2'd0;
      r_code     <= 4'h0;
      r_valid    <= 1'b0;
      r_pulse    <= 1'b0;
      r_row_out  <= ~ROW_ONE;
    end else begin
      r_col_m    <= col_in;
      r_col_s    <= r_col_m;
      r_state    <= w_state;
      r_row      <= w_row;
      r_dwell    <= w_tick ? '0 : r_dwell + 1'b1;
      r_cnt      <= w_cnt;
      r_cand_row <= w_cand_row;
      r_cand_col <= w_cand_col;
      r_code     <= w_code;
      r_valid    <= w_valid;
      r_pulse    <= w_pulse;
      r_row_out  <= w_row_out;
    end
  end

  assign row_out   = r_row_out;
  assign code      = r_code;
  assign valid     = r_valid;
  assign key_pulse = r_pulse;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed dwell table, reset-while-held
// sequence and random key traffic against a dwell-level key model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  code;
  logic        valid;
  logic        key_pulse;
  logic [11:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_out(row_out),
    .code(code),
    .valid(valid),
    .key_pulse(key_pulse)
  );

  // Key id = row*3 + col; '1'..'9', '*', '0', '#'.
  function automatic logic [2:0] matrix(
    input logic [3:0]  ro,
    input logic [11:0] k
  );
    logic [2:0] c;
    c = 3'b111;
    for (int r = 0; r < 4; r++)
      if (!ro[r])
        for (int j = 0; j < 3; j++)
          if (k[r*3+j]) c[2-j] = 1'b0;
    return c;
  endfunction

  assign col_in = matrix(row_out, keys);

  function automatic int sample_key(
    input int          row,
    input logic [11:0] k
  );
    int n;
    int id;
    n  = 0;
    id = -1;
    for (int j = 0; j < 3; j++)
      if (k[row*3+j]) begin
        n++;
        id = row * 3 + j;
      end
    return (n == 1) ? id : -1;
  endfunction

  logic [3:0] kcode [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                             4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dwell(input logic mid_valid);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        chk("mid_valid", 32'(valid), 32'(mid_valid));
        chk("mid_pulse", 32'(key_pulse), 32'd0);
      end else if (key_pulse) begin
        pulses_seen++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_row", 32'(row_out), 32'h0e);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pulse", 32'(key_pulse), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pulses_seen = 0;
  endtask

  typedef struct {
    logic [11:0] keys;
    logic [3:0]  row;
    logic        valid;
    logic [3:0]  code;
    int          pulses;
  } vec_t;

  localparam logic [11:0] K0 = 12'h000;
  localparam logic [11:0] K1 = 12'h001;
  localparam logic [11:0] K5 = 12'h010;
  localparam logic [11:0] KH = 12'h800;
  localparam logic [11:0] K23 = 12'h006;

  vec_t tbl [25];

  int         m_row;
  int         m_run;
  int         m_miss;
  int         m_key;
  bit         m_locked;
  logic       m_valid;
  logic [3:0] m_code;
  int         m_pulses;

  task automatic model_step(input logic [11:0] k);
    int s;
    s = sample_key(m_row, k);
    if (!m_locked) begin
      if (m_run == 0) begin
        if (s >= 0) begin
          m_key = s;
          m_run = 1;
        end else begin
          m_row = (m_row + 1) % 4;
        end
      end else if (s == m_key) begin
        m_run++;
        if (m_run == 3) begin
          m_locked = 1'b1;
          m_valid  = 1'b1;
          m_code   = kcode[m_key];
          m_pulses++;
          m_run    = 0;
          m_miss   = 0;
        end
      end else begin
        m_run = 0;
        m_row = (m_row + 1) % 4;
      end
    end else if (s == m_key) begin
      m_miss = 0;
    end else begin
      m_miss++;
      if (m_miss == 3) begin
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_miss   = 0;
        m_row    = (m_row + 1) % 4;
      end
    end
  endtask

  initial begin
    logic        prev_v;
    logic        mid;
    logic [3:0]  er;
    logic [11:0] one;
    int          r;

    tbl[0]  = '{K0,  4'b1101, 1'b0, 4'h0, 0};
    tbl[1]  = '{K0,  4'b1011, 1'b0, 4'h0, 0};
    tbl[2]  = '{K0,  4'b0111, 1'b0, 4'h0, 0};
    tbl[3]  = '{K0,  4'b1110, 1'b0, 4'h0, 0};
    tbl[4]  = '{K0,  4'b1101, 1'b0, 4'h0, 0};
    tbl[5]  = '{K5,  4'b1101, 1'b0, 4'h0, 0};
    tbl[6]  = '{K5,  4'b1101, 1'b0, 4'h0, 0};
    tbl[7]  = '{K5,  4'b1101, 1'b1, 4'h5, 1};
    tbl[8]  = '{K5,  4'b1101, 1'b1, 4'h5, 1};
    tbl[9]  = '{K0,  4'b1101, 1'b1, 4'h5, 1};
    tbl[10] = '{K0,  4'b1101, 1'b1, 4'h5, 1};
    tbl[11] = '{K0,  4'b1011, 1'b0, 4'h5, 1};
    tbl[12] = '{KH,  4'b0111, 1'b0, 4'h5, 1};
    tbl[13] = '{KH,  4'b0111, 1'b0, 4'h5, 1};
    tbl[14] = '{K0,  4'b1110, 1'b0, 4'h5, 1};
    tbl[15] = '{K23, 4'b1101, 1'b0, 4'h5, 1};
    tbl[16] = '{K23, 4'b1011, 1'b0, 4'h5, 1};
    tbl[17] = '{K0,  4'b0111, 1'b0, 4'h5, 1};
    tbl[18] = '{K0,  4'b1110, 1'b0, 4'h5, 1};
    tbl[19] = '{K1,  4'b1110, 1'b0, 4'h5, 1};
    tbl[20] = '{K1,  4'b1110, 1'b0, 4'h5, 1};
    tbl[21] = '{K1,  4'b1110, 1'b1, 4'h1, 2};
    tbl[22] = '{K0,  4'b1110, 1'b1, 4'h1, 2};
    tbl[23] = '{K1,  4'b1110, 1'b1, 4'h1, 2};
    tbl[24] = '{K1,  4'b1110, 1'b1, 4'h1, 2};

    do_reset();
    prev_v = 1'b0;
    for (int i = 0; i < 25; i++) begin
      keys = tbl[i].keys;
      dwell(prev_v);
      chk($sformatf("tbl%0d_row", i), 32'(row_out), 32'(tbl[i].row));
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_code", i), 32'(code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_pulses", i), 32'(pulses_seen),
          32'(tbl[i].pulses));
      prev_v = tbl[i].valid;
    end

    // Reset while '1' is held, then re-acceptance with full latency.
    do_reset();
    dwell(1'b0);
    chk("rehold_v1", 32'(valid), 32'd0);
    dwell(1'b0);
    chk("rehold_v2", 32'(valid), 32'd0);
    dwell(1'b0);
    chk("rehold_v3", 32'(valid), 32'd1);
    chk("rehold_code", 32'(code), 32'd1);
    chk("rehold_row", 32'(row_out), 32'h0e);
    chk("rehold_pulses", 32'(pulses_seen), 32'd1);

    keys = K0;
    do_reset();
    m_row = 0;
    m_run = 0;
    m_miss = 0;
    m_key = -1;
    m_locked = 1'b0;
    m_valid = 1'b0;
    m_code = 4'h0;
    m_pulses = 0;
    one = 12'h001;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 30) begin
        r = int'($urandom_range(99));
        if (r < 40) keys = K0;
        else if (r < 85) keys = one << $urandom_range(11);
        else keys = (one << $urandom_range(11)) |
                    (one << $urandom_range(11));
      end
      mid = m_valid;
      dwell(mid);
      model_step(keys);
      er = ~(4'b0001 << m_row);
      chk("rnd_row", 32'(row_out), 32'(er));
      chk("rnd_valid", 32'(valid), 32'(m_valid));
      chk("rnd_code", 32'(code), 32'(m_code));
      chk("rnd_pulses", 32'(pulses_seen), 32'(m_pulses));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
